track_sensor_frontend: RTL and testbench

//  Upstream stage of the TrainGuard axle/car counter. Samples two raw track

---
 rtl/track_sensor_frontend.sv | 190 +++++++++++++++++++
 tb/tb_track_sensor_frontend.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/track_sensor_frontend.sv
// track_sensor_frontend
// Upstream stage of the TrainGuard axle/car counter. The two raw track
// sensors are synchronised, then debounced. A pass FSM works out the
// direction of travel from which sensor trips first. Each completed pass
// gives one strobe cycle, so the downstream counter moves by exactly +/-1
// per vehicle.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears all state
//   raw_s1     asynchronous raw sensor S1 (upstream rail), 1 = occupied
//   raw_s2     asynchronous raw sensor S2 (downstream rail), 1 = occupied
//   B1, B2     pass strobe pair to the counter; always equal, one cycle wide
//   prefernce  direction: 1 = S1->S2 (count up), 0 = S2->S1 (count down)
//   s1_level   debounced S1 level
//   s2_level   debounced S2 level
//   err        sticky fault flag (ambiguous start or pass timeout)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | track clear, waiting for the first sensor to trip
// S1_FIRST | only S1 occupied so far; direction latched as up
// S2_FIRST | only S2 occupied so far; direction latched as down
// BOTH     | both sensors occupied; this pass is now countable
// CLEARING | waiting for both sensors to clear before returning to IDLE
// FAULT    | pass took too long; wait for a clear track

module track_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_s1,
    input  logic raw_s2,
    output logic B1,
    output logic B2,
    output logic prefernce,
    output logic s1_level,
    output logic s2_level,
    output logic err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        S1_FIRST,
        S2_FIRST,
        BOTH,
        CLEARING,
        FAULT
    } state_t;

    // Index 0 carries S1, index 1 carries S2.
    logic [1:0]      sync_meta;
    logic [1:0]      sync_out;
    logic [1:0]      level;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            pass_ok;
    logic            l1;
    logic            l2;
    logic            timeout;

    assign s1_level = level[0];
    assign s2_level = level[1];
    assign l1       = level[0];
    assign l2       = level[1];
    assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching
    // synced sample. Any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
            level     <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_meta <= {raw_s2, raw_s1};
            sync_out  <= sync_meta;
            for (int i = 0; i < 2; i++) begin
                if (sync_out[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= sync_out[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Timeout takes priority over a normal exit in the same cycle, so no
    // pass state is ever held for more than TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            to_cnt    <= '0;
            pass_ok   <= 1'b0;
            B1        <= 1'b0;
            B2        <= 1'b0;
            prefernce <= 1'b1;
            err       <= 1'b0;
        end else begin
            B1 <= 1'b0;
            B2 <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt  <= '0;
                    pass_ok <= 1'b0;
                    if (l1 && l2) begin
                        state <= CLEARING;
                        err   <= 1'b1;
                    end else if (l1) begin
                        state     <= S1_FIRST;
                        prefernce <= 1'b1;
                    end else if (l2) begin
                        state     <= S2_FIRST;
                        prefernce <= 1'b0;
                    end
                end
                S1_FIRST, S2_FIRST: begin
                    if (timeout) begin
                        state  <= FAULT;
                        err    <= 1'b1;
                        to_cnt <= '0;
                    end else if (l1 && l2) begin
                        state   <= BOTH;
                        pass_ok <= 1'b1;
                        to_cnt  <= '0;
                    end else if (!l1 && !l2) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                BOTH: begin
                    if (timeout) begin
                        state  <= FAULT;
                        err    <= 1'b1;
                        to_cnt <= '0;
                    end else if (!(l1 && l2)) begin
                        state  <= CLEARING;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CLEARING: begin
                    if (timeout) begin
                        state  <= FAULT;
                        err    <= 1'b1;
                        to_cnt <= '0;
                    end else if (!l1 && !l2) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                        B1     <= pass_ok;
                        B2     <= pass_ok;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                FAULT: begin
                    if (!l1 && !l2) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    to_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_track_sensor_frontend.sv
// tb_track_sensor_frontend
// Self-checking bench for track_sensor_frontend (DEBOUNCE_CYCLES=4,
// TIMEOUT_CYCLES=64). Expected strobe directions are queued as each pass is
// driven; the strobe monitor pops and compares them. A bench-side counter
// fed by the strobes is checked against the model count.

module tb_track_sensor_frontend;

    logic clk = 1'b0;
    logic reset;
    logic raw_s1;
    logic raw_s2;
    logic B1;
    logic B2;
    logic prefernce;
    logic s1_level;
    logic s2_level;
    logic err;

    int   checks = 0;
    int   errors = 0;
    int   strobe_cnt = 0;
    int   tb_count = 0;
    int   exp_count = 0;
    bit   prev_b = 1'b0;
    bit   exp_q [$];

    track_sensor_frontend #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_s1   (raw_s1),
        .raw_s2   (raw_s2),
        .B1       (B1),
        .B2       (B2),
        .prefernce(prefernce),
        .s1_level (s1_level),
        .s2_level (s2_level),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_b1"},   int'(B1), 0);
        chk({tag, "_b2"},   int'(B2), 0);
        chk({tag, "_pref"}, int'(prefernce), 1);
        chk({tag, "_l1"},   int'(s1_level), 0);
        chk({tag, "_l2"},   int'(s2_level), 0);
        chk({tag, "_err"},  int'(err), 0);
    endtask

    // Clean pass: first sensor at t0, second at t0+20, first clears at
    // t0+40, second clears at t0+60, then settle.
    task automatic do_pass(input bit s1_first, input string tag);
        exp_q.push_back(s1_first);
        exp_count += s1_first ? 1 : -1;
        if (s1_first) raw_s1 = 1'b1; else raw_s2 = 1'b1;
        wait_cyc(10);
        chk({tag, "_pref_early"}, int'(prefernce), int'(s1_first));
        wait_cyc(10);
        if (s1_first) raw_s2 = 1'b1; else raw_s1 = 1'b1;
        wait_cyc(20);
        if (s1_first) raw_s1 = 1'b0; else raw_s2 = 1'b0;
        wait_cyc(20);
        if (s1_first) raw_s2 = 1'b0; else raw_s1 = 1'b0;
        wait_cyc(20);
    endtask

    // Strobe monitor.
    always @(negedge clk) begin
        if (B1 || B2) begin
            chk("strobe_pair", int'(B2), int'(B1));
            chk("strobe_gap", int'(prev_b), 0);
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", 1, 0);
            end else begin
                chk("strobe_dir", int'(prefernce), int'(exp_q.pop_front()));
            end
            strobe_cnt++;
            tb_count += prefernce ? 1 : -1;
        end
        prev_b = B1 || B2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset  = 1'b1;
        raw_s1 = 1'b0;
        raw_s2 = 1'b0;
        wait_cyc(3);
        chk_reset_vals("rst");
        reset = 1'b0;
        wait_cyc(3);

        // 1: S1 then S2
        st = strobe_cnt;
        do_pass(1'b1, "t1");
        chk("t1_strobes", strobe_cnt - st, 1);
        chk("t1_err", int'(err), 0);
        chk("t1_count", tb_count, exp_count);

        // 2: mirror
        st = strobe_cnt;
        do_pass(1'b0, "t2");
        chk("t2_strobes", strobe_cnt - st, 1);
        chk("t2_count", tb_count, exp_count);

        // 3: 3-cycle glitches are filtered
        st = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            raw_s1 = 1'b1;
            wait_cyc(3);
            raw_s1 = 1'b0;
            wait_cyc(3);
            chk("t3_level", int'(s1_level), 0);
            wait_cyc(4);
        end
        chk("t3_strobes", strobe_cnt - st, 0);

        // 4: S1 only, backs out
        st = strobe_cnt;
        raw_s1 = 1'b1;
        wait_cyc(4);
        chk("t4_level_before", int'(s1_level), 0);
        wait_cyc(4);
        chk("t4_level_after", int'(s1_level), 1);
        wait_cyc(22);
        raw_s1 = 1'b0;
        wait_cyc(30);
        chk("t4_strobes", strobe_cnt - st, 0);
        chk("t4_err", int'(err), 0);
        chk("t4_level_low", int'(s1_level), 0);

        // 5: simultaneous rise is ambiguous; a later clean pass still counts
        st = strobe_cnt;
        raw_s1 = 1'b1;
        raw_s2 = 1'b1;
        wait_cyc(20);
        chk("t5_err", int'(err), 1);
        raw_s1 = 1'b0;
        raw_s2 = 1'b0;
        wait_cyc(20);
        chk("t5_no_strobe", strobe_cnt - st, 0);
        do_pass(1'b1, "t5b");
        chk("t5_clean_strobes", strobe_cnt - st, 1);
        chk("t5_err_sticky", int'(err), 1);
        chk("t5_count", tb_count, exp_count);

        // 6: timeout into FAULT, then reset in the middle of a later pass
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        chk("t6_err_cleared", int'(err), 0);
        st = strobe_cnt;
        raw_s1 = 1'b1;
        wait_cyc(66);
        chk("t6_err_pre_timeout", int'(err), 0);
        wait_cyc(8);
        chk("t6_err_post_timeout", int'(err), 1);
        wait_cyc(26);
        raw_s1 = 1'b0;
        wait_cyc(20);
        chk("t6_fault_strobes", strobe_cnt - st, 0);
        raw_s2 = 1'b1;
        wait_cyc(10);
        raw_s1 = 1'b1;
        wait_cyc(15);
        chk("t6_pref_midpass", int'(prefernce), 0);
        reset  = 1'b1;
        raw_s1 = 1'b0;
        raw_s2 = 1'b0;
        wait_cyc(1);
        chk_reset_vals("t6_midrst");
        reset = 1'b0;
        wait_cyc(40);
        chk("t6_dropped_strobe", strobe_cnt - st, 0);

        chk("sb_leftover", exp_q.size(), 0);
        chk("final_count", tb_count, exp_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
